// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result path:
//   - default widths of the result word and of the selector (operation) code
//   - the eight selector codes produced by the upstream result selector
//   - the occupancy states of the result stage skid buffer
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_SEL_W  = 3;

  // Operation tags that travel alongside each result word.
  typedef enum logic [2:0] {
    SEL_ADD  = 3'd0,
    SEL_SUB  = 3'd1,
    SEL_AND  = 3'd2,
    SEL_OR   = 3'd3,
    SEL_XOR  = 3'd4,
    SEL_SHL  = 3'd5,
    SEL_SHR  = 3'd6,
    SEL_PASS = 3'd7
  } alu_sel_e;

  // Number of words held in the stage: none, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/result_flags.sv
// ---------------------------------------------------------------------------
// result_flags
// Combinational zero / negative flag generation for a result word.
// Ports:
//   data_i  [DATA_W-1:0]  result word
//   zero_o                1 when every bit of data_i is 0
//   neg_o                 sign bit of data_i (two's-complement negative)
// ---------------------------------------------------------------------------
module result_flags
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              zero_o,
  output logic              neg_o
);

  assign zero_o = (data_i == {DATA_W{1'b0}});
  assign neg_o  = data_i[DATA_W-1];

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Registered output stage for the ALU result selector. A two-entry skid
// buffer (main register facing the outputs, skid register behind it) lets
// in_ready be a pure flop while still sustaining one word per cycle.
// Zero/negative flags are computed once at capture and stored with the word.
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is registered)
//   in_data, in_sel          result word and the selector code that made it
//   out_valid / out_ready    downstream handshake
//   out_data, out_sel        registered word and its operation tag
//   out_zero, out_neg        flags stored with the word
//   out_count                completed output handshakes, modulo 256
// ---------------------------------------------------------------------------
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned SEL_W  = ALU_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_zero,
  output logic              out_neg,
  output logic [7:0]        out_count
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_sel_q, main_sel_d;
  logic              main_zero_q, main_zero_d;
  logic              main_neg_q, main_neg_d;

  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
  logic              skid_zero_q, skid_zero_d;
  logic              skid_neg_q, skid_neg_d;

  logic [7:0]        count_q, count_d;

  logic              accept_s;
  logic              drain_s;
  logic              cap_zero_s;
  logic              cap_neg_s;

  // Flags for the incoming word, evaluated only on the capture path.
  result_flags #(
    .DATA_W (DATA_W)
  ) u_result_flags (
    .data_i (in_data),
    .zero_o (cap_zero_s),
    .neg_o  (cap_neg_s)
  );

  // in_ready_q is exactly (state != TWO), so an accept can never hit a full stage.
  assign accept_s = in_valid && in_ready_q;
  assign drain_s  = out_valid_q && out_ready;

  // Next-state, buffer steering and handshake counter.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_zero_d = main_zero_q;
    main_neg_d  = main_neg_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_zero_d = skid_zero_q;
    skid_neg_d  = skid_neg_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_data_d = in_data;
          main_sel_d  = in_sel;
          main_zero_d = cap_zero_s;
          main_neg_d  = cap_neg_s;
          state_d     = ST_ONE;
        end else begin
          state_d     = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          // Streaming case: the new word replaces the one leaving.
          main_data_d = in_data;
          main_sel_d  = in_sel;
          main_zero_d = cap_zero_s;
          main_neg_d  = cap_neg_s;
          state_d     = ST_ONE;
        end else if (accept_s) begin
          // Output stalled: park the new word behind the main register.
          skid_data_d = in_data;
          skid_sel_d  = in_sel;
          skid_zero_d = cap_zero_s;
          skid_neg_d  = cap_neg_s;
          state_d     = ST_TWO;
        end else if (drain_s) begin
          state_d     = ST_EMPTY;
        end else begin
          state_d     = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          main_zero_d = skid_zero_q;
          main_neg_d  = skid_neg_q;
          state_d     = ST_ONE;
        end else begin
          state_d     = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Ready and valid are decoded from the next state so both leave flops.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);

    if (drain_s) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State, buffer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_data_q <= {DATA_W{1'b0}};
      main_sel_q  <= {SEL_W{1'b0}};
      main_zero_q <= 1'b0;
      main_neg_q  <= 1'b0;
      skid_data_q <= {DATA_W{1'b0}};
      skid_sel_q  <= {SEL_W{1'b0}};
      skid_zero_q <= 1'b0;
      skid_neg_q  <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_zero_q <= main_zero_d;
      main_neg_q  <= main_neg_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_zero_q <= skid_zero_d;
      skid_neg_q  <= skid_neg_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_zero  = main_zero_q;
  assign out_neg   = main_neg_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic [7:0]  out_count;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_result_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {sel, data, zero, neg} of a word as the bench expects it at the output
  function automatic logic [20:0] exp_word(input logic [15:0] d, input logic [2:0] s);
    return {s, d, (d == 16'h0000), d[15]};
  endfunction

  function automatic logic [15:0] stream_val(input int i);
    logic [31:0] t;
    t = i * 32'h0000_0137 + 32'h0000_7F00;
    return t[15:0];
  endfunction

  initial begin
    logic [20:0] sb[$];
    logic [20:0] w;
    logic [15:0] d;
    logic [2:0]  s;
    logic        iv, orr, acc, drn;
    int          mdl_count;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_sel = 3'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_fields",    {11'd0, out_sel, out_data, out_zero, out_neg}, 32'd0);
    check("rst_count",     {24'd0, out_count}, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    check("empty_after_rst",    {31'd0, out_valid}, 32'd0);

    // Zero result, tag 3, immediate drain
    in_valid = 1'b1; in_data = 16'h0000; in_sel = 3'd3; out_ready = 1'b1;
    @(negedge clk);
    check("zero_word", {10'd0, out_valid, out_sel, out_data, out_zero, out_neg},
          {10'd0, 1'b1, 3'd3, 16'h0000, 1'b1, 1'b0});
    check("zero_count_before", {24'd0, out_count}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("zero_count_after", {24'd0, out_count}, 32'd1);
    check("zero_drained",     {31'd0, out_valid}, 32'd0);

    // Fill both entries with the output stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h8001; in_sel = 3'd1;
    @(negedge clk);
    check("one_in_ready", {31'd0, in_ready}, 32'd1);
    in_data = 16'h0005; in_sel = 3'd2;
    @(negedge clk);
    check("two_in_ready", {31'd0, in_ready}, 32'd0);
    check("two_head", {10'd0, out_valid, out_sel, out_data, out_zero, out_neg},
          {10'd0, 1'b1, 3'd1, 16'h8001, 1'b0, 1'b1});

    // Stall 5 cycles with in_data toggling: outputs must not move
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = (k % 2 == 0) ? 16'hFFFF : 16'h1234;
      in_sel   = 3'(k);
      @(negedge clk);
      check("stall_hold", {10'd0, out_valid, out_sel, out_data, out_zero, out_neg},
            {10'd0, 1'b1, 3'd1, 16'h8001, 1'b0, 1'b1});
    end

    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("fifo_second", {10'd0, out_valid, out_sel, out_data, out_zero, out_neg},
          {10'd0, 1'b1, 3'd2, 16'h0005, 1'b0, 1'b0});
    check("fifo_count2", {24'd0, out_count}, 32'd2);
    check("fifo_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("fifo_empty",  {31'd0, out_valid}, 32'd0);
    check("fifo_count3", {24'd0, out_count}, 32'd3);

    // Reset, then stream 300 words back to back
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = stream_val(i);
      in_sel   = 3'(i);
      @(negedge clk);
      check("stream_word", {9'd0, in_ready, out_valid, out_sel, out_data, out_zero, out_neg},
            {9'd0, 1'b1, 1'b1, exp_word(stream_val(i), 3'(i))});
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_done",  {31'd0, out_valid}, 32'd0);
    check("stream_count", {24'd0, out_count}, 32'd44);

    // Reset while holding two words
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 3'd5;
    @(negedge clk);
    in_data = 16'h5555; in_sel = 3'd6;
    @(negedge clk);
    check("pre_rst_two", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b1});
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", {22'd0, out_count, in_ready, out_valid}, 32'd0);
    check("midrst_data",  {16'd0, out_data}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_emit", {23'd0, out_count, out_valid}, 32'd0);
    end

    // Random traffic against a scoreboard FIFO
    mdl_count = 0;
    for (int c = 0; c < 2000; c++) begin
      check("rnd_in_ready",  {31'd0, in_ready},  {31'd0, (sb.size() < 2)});
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      if (sb.size() != 0) begin
        check("rnd_word", {11'd0, out_sel, out_data, out_zero, out_neg}, {11'd0, sb[0]});
      end
      iv  = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 1));
      in_valid  = iv;
      out_ready = orr;
      if (iv) begin
        d = 16'($urandom);
        if ($urandom_range(0, 7) == 0) d = 16'h0000;
        s = 3'($urandom);
        in_data = d;
        in_sel  = s;
      end else begin
        in_data = 16'hxxxx;
        in_sel  = 3'bxxx;
      end
      acc = iv && in_ready;
      drn = out_valid && orr;
      if (drn) begin
        void'(sb.pop_front());
        mdl_count++;
      end
      if (acc) begin
        sb.push_back(exp_word(d, s));
      end
      @(negedge clk);
    end

    // Drain what is left (bounded)
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) begin
        w = (sb.size() != 0) ? sb[0] : 21'h1FFFFF;
        check("drain_word", {11'd0, out_sel, out_data, out_zero, out_neg}, {11'd0, w});
        if (sb.size() != 0) void'(sb.pop_front());
        mdl_count++;
      end
      @(negedge clk);
    end
    check("drain_empty", {30'd0, out_valid, (sb.size() != 0)}, 32'd0);
    check("rnd_count",   {24'd0, out_count}, {24'd0, 8'(mdl_count)});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
